usb_dev_responder: RTL and testbench

Device-side protocol responder for the USB thumb-drive link. Sits between the device's packet decoder/encoder and its 64 KiB × 64-bit backing memory. It answers the host's address-OUT, data-OUT and data-IN transactions with ACK/NAK handshakes, memory writes and DATA0 replies.

---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_dev_timer.sv | 33 +++
 rtl/usb_dev_responder.sv | 193 +++++++++++++++++++
 tb/tb_usb_dev_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB device responder: PIDs, FSM states and
// default device/endpoint numbers.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SEND_HS   = 3'd2,
        ST_MEM_RD    = 3'd3,
        ST_MEM_CAP   = 3'd4,
        ST_SEND_DATA = 3'd5,
        ST_WAIT_HS   = 3'd6
    } state_t;

    localparam logic [6:0] DEF_DEV_ADDR = 7'd5;
    localparam logic [3:0] DEF_ADDR_EP  = 4'd4;
    localparam logic [3:0] DEF_DATA_EP  = 4'd8;

endpackage

// File: rtl/usb_dev_timer.sv
// Clearable cycle counter used to abandon transactions when the host goes
// quiet. Counts while i_run is high, holds zero otherwise, and flags the
// cycle in which the count reaches TIMEOUT-1.
module usb_dev_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_L,
    input  logic i_run,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Count wait cycles; zero whenever not waiting, saturate at the last value.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = i_run && (r_cnt == LAST);

endmodule

// File: rtl/usb_dev_responder.sv
// Device-side USB responder: answers address-OUT, data-OUT and data-IN
// transactions with handshakes, memory writes and DATA0 replies.
module usb_dev_responder
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter logic [3:0] ADDR_EP   = DEF_ADDR_EP,
    parameter logic [3:0] DATA_EP   = DEF_DATA_EP,
    parameter int         TIMEOUT   = 255,
    parameter int         MAX_RETRY = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic        rx_ok,
    output logic        tx_req,
    output logic [3:0]  tx_pid,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [63:0] mem_rdata
);

    state_t      r_state;
    logic [3:0]  r_ep;
    logic [15:0] r_addr;
    logic        r_addr_valid;
    logic [3:0]  r_retry;
    logic        r_tx_req;
    logic [3:0]  r_tx_pid;
    logic [63:0] r_tx_data;
    logic [15:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_mem_re;

    logic w_timer_run;
    logic w_timeout;
    logic w_tok_hit;
    logic w_data0_ok;

    assign w_timer_run = (r_state == ST_WAIT_DATA) || (r_state == ST_WAIT_HS);
    assign w_tok_hit   = (rx_addr == DEV_ADDR);
    assign w_data0_ok  = (rx_pid == PID_DATA0) && rx_ok;

    usb_dev_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_L     (rst_L),
        .i_run     (w_timer_run),
        .o_expired (w_timeout)
    );

    // Transaction FSM with all outputs and bookkeeping registered.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state      <= ST_IDLE;
            r_ep         <= 4'd0;
            r_addr       <= 16'd0;
            r_addr_valid <= 1'b0;
            r_retry      <= 4'd0;
            r_tx_req     <= 1'b0;
            r_tx_pid     <= 4'd0;
            r_tx_data    <= 64'd0;
            r_mem_addr   <= 16'd0;
            r_mem_wdata  <= 64'd0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
        end else begin
            // Memory strobes are single-cycle unless re-asserted below.
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && w_tok_hit) begin
                        if ((rx_pid == PID_OUT) &&
                            ((rx_endp == ADDR_EP) || (rx_endp == DATA_EP))) begin
                            r_ep    <= rx_endp;
                            r_state <= ST_WAIT_DATA;
                        end else if ((rx_pid == PID_IN) && (rx_endp == DATA_EP)) begin
                            if (r_addr_valid) begin
                                r_mem_addr <= r_addr;
                                r_mem_re   <= 1'b1;
                                r_retry    <= 4'd0;
                                r_state    <= ST_MEM_RD;
                            end else begin
                                r_tx_pid <= PID_NAK;
                                r_tx_req <= 1'b1;
                                r_state  <= ST_SEND_HS;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_DATA: begin
                    // A packet arriving in the timeout cycle still wins.
                    if (rx_valid) begin
                        if (w_data0_ok && (r_ep == ADDR_EP)) begin
                            r_addr       <= rx_data[15:0];
                            r_addr_valid <= 1'b1;
                            r_tx_pid     <= PID_ACK;
                        end else if (w_data0_ok && (r_ep == DATA_EP) && r_addr_valid) begin
                            r_mem_addr   <= r_addr;
                            r_mem_wdata  <= rx_data;
                            r_mem_we     <= 1'b1;
                            r_addr_valid <= 1'b0;
                            r_tx_pid     <= PID_ACK;
                        end else begin
                            r_tx_pid <= PID_NAK;
                        end
                        r_tx_req <= 1'b1;
                        r_state  <= ST_SEND_HS;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_DATA;
                    end
                end
                ST_SEND_HS: begin
                    if (tx_done) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_state <= ST_SEND_HS;
                    end
                end
                ST_MEM_RD: begin
                    r_state <= ST_MEM_CAP;
                end
                ST_MEM_CAP: begin
                    r_tx_data <= mem_rdata;
                    r_tx_pid  <= PID_DATA0;
                    r_tx_req  <= 1'b1;
                    r_state   <= ST_SEND_DATA;
                end
                ST_SEND_DATA: begin
                    if (tx_done) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_WAIT_HS;
                    end else begin
                        r_state <= ST_SEND_DATA;
                    end
                end
                ST_WAIT_HS: begin
                    if (rx_valid) begin
                        if (rx_ok && (rx_pid == PID_ACK)) begin
                            r_addr_valid <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else if (!rx_ok || (rx_pid == PID_NAK)) begin
                            // Resend the captured data until retries run out;
                            // the address stays valid so the host can retry later.
                            if (r_retry < 4'(MAX_RETRY)) begin
                                r_retry  <= r_retry + 4'd1;
                                r_tx_req <= 1'b1;
                                r_state  <= ST_SEND_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_state <= ST_WAIT_HS;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_HS;
                    end
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_req    = r_tx_req;
    assign tx_pid    = r_tx_pid;
    assign tx_data   = r_tx_data;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_usb_dev_responder.sv
// Directed self-checking bench for usb_dev_responder.
module tb_usb_dev_responder;
    import usb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rx_pid = 4'd0;
    logic [6:0]  rx_addr = 7'd0;
    logic [3:0]  rx_endp = 4'd0;
    logic [63:0] rx_data = 64'd0;
    logic        rx_ok = 1'b0;
    logic        tx_req;
    logic [3:0]  tx_pid;
    logic [63:0] tx_data;
    logic        tx_done = 1'b0;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_rdata = 64'd0;

    int total = 0;
    int bad = 0;

    usb_dev_responder dut (
        .clk(clk), .rst_L(rst_L),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_addr(rx_addr),
        .rx_endp(rx_endp), .rx_data(rx_data), .rx_ok(rx_ok),
        .tx_req(tx_req), .tx_pid(tx_pid), .tx_data(tx_data), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [15:0] a);
        if (a == 16'h1234) return 64'hDEAD_BEEF_0123_4567;
        else return {16'hC0DE, 32'h0, a};
    endfunction

    // Backing memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_model(mem_addr);
    end

    typedef struct {
        logic [6:0]  tok_addr;
        logic [3:0]  tok_ep;
        logic [3:0]  dpid;
        logic [63:0] data;
        logic        ok;
        logic        exp_req;
        logic [3:0]  exp_pid;
        logic        exp_we;
        logic [15:0] exp_waddr;
    } wvec_t;

    wvec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle packet; returns at the negedge of the following cycle.
    task automatic send_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] ep,
                            input logic [63:0] d, input logic ok);
        @(negedge clk);
        rx_valid = 1'b1; rx_pid = pid; rx_addr = a; rx_endp = ep; rx_data = d; rx_ok = ok;
        @(negedge clk);
        rx_valid = 1'b0; rx_ok = 1'b0;
    endtask

    task automatic wait_tx(input int max, output bit got);
        got = 1'b0;
        for (int c = 0; c < max && !got; c++) begin
            if (tx_req) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic do_hs(input string name, input logic [3:0] exp_pid);
        check({name, "_req"}, {63'd0, tx_req}, 64'd1);
        check({name, "_pid"}, {60'd0, tx_pid}, {60'd0, exp_pid});
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({name, "_drop"}, {63'd0, tx_req}, 64'd0);
        check({name, "_we1"}, {63'd0, mem_we}, 64'd0);
    endtask

    initial begin
        bit got;
        int sends;

        vecs[0] = '{7'd5, 4'd4, PID_DATA0, 64'h0123_4567_89AB_FFFF, 1'b1, 1'b1, PID_ACK, 1'b0, 16'h0};
        vecs[1] = '{7'd5, 4'd8, PID_DATA0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, PID_ACK, 1'b1, 16'hFFFF};
        vecs[2] = '{7'd5, 4'd8, PID_DATA0, 64'h5555_5555_5555_5555, 1'b1, 1'b1, PID_NAK, 1'b0, 16'h0};
        vecs[3] = '{7'd5, 4'd4, PID_DATA0, 64'h0000_0000_0000_1234, 1'b1, 1'b1, PID_ACK, 1'b0, 16'h0};
        vecs[4] = '{7'd5, 4'd4, PID_DATA0, 64'h0000_0000_0000_BEEF, 1'b0, 1'b1, PID_NAK, 1'b0, 16'h0};
        vecs[5] = '{7'd5, 4'd4, PID_DATA1, 64'h0000_0000_0000_7777, 1'b1, 1'b1, PID_NAK, 1'b0, 16'h0};
        vecs[6] = '{7'd6, 4'd4, PID_DATA0, 64'h0000_0000_0000_9999, 1'b1, 1'b0, PID_ACK, 1'b0, 16'h0};
        vecs[7] = '{7'd5, 4'd3, PID_DATA0, 64'h0000_0000_0000_8888, 1'b1, 1'b0, PID_ACK, 1'b0, 16'h0};
        vecs[8] = '{7'd5, 4'd8, PID_DATA0, 64'hA5A5_5A5A_A5A5_5A5A, 1'b1, 1'b1, PID_ACK, 1'b1, 16'h1234};
        vecs[9] = '{7'd5, 4'd4, PID_DATA0, 64'h0000_0000_0000_1234, 1'b1, 1'b1, PID_ACK, 1'b0, 16'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", {63'd0, tx_req}, 64'd0);
        check("rst_pid", {60'd0, tx_pid}, 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_maddr", {48'd0, mem_addr}, 64'd0);
        check("rst_we_re", {62'd0, mem_we, mem_re}, 64'd0);
        rst_L = 1'b1;
        @(negedge clk);

        // Table: OUT token followed by a data packet
        for (int i = 0; i < 10; i++) begin
            send_pkt(PID_OUT, vecs[i].tok_addr, vecs[i].tok_ep, 64'd0, 1'b1);
            check($sformatf("v%0d_tok", i), {63'd0, tx_req}, 64'd0);
            send_pkt(vecs[i].dpid, 7'd0, 4'd0, vecs[i].data, vecs[i].ok);
            check($sformatf("v%0d_req", i), {63'd0, tx_req}, {63'd0, vecs[i].exp_req});
            check($sformatf("v%0d_we", i), {63'd0, mem_we}, {63'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_waddr", i), {48'd0, mem_addr}, {48'd0, vecs[i].exp_waddr});
                check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].data);
            end
            if (vecs[i].exp_req) begin
                do_hs($sformatf("v%0d_hs", i), vecs[i].exp_pid);
            end else begin
                @(negedge clk);
                check($sformatf("v%0d_quiet", i), {62'd0, tx_req, mem_we}, 64'd0);
            end
        end

        // Read at 0x1234 with host ACK
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        check("rd_re", {63'd0, mem_re}, 64'd1);
        check("rd_addr", {48'd0, mem_addr}, 64'h1234);
        check("rd_n1_req", {63'd0, tx_req}, 64'd0);
        @(negedge clk);
        check("rd_n2", {62'd0, mem_re, tx_req}, 64'd0);
        @(negedge clk);
        check("rd_n3_data", tx_data, 64'hDEAD_BEEF_0123_4567);
        do_hs("rd_hs", PID_DATA0);
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);
        check("rd_ack_quiet", {63'd0, tx_req}, 64'd0);

        // IN after ACK: address consumed, so NAK and no read
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        check("in_noaddr_re", {63'd0, mem_re}, 64'd0);
        do_hs("in_noaddr", PID_NAK);

        // Retry exhaustion
        send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h42, 1'b1);
        do_hs("rt_addr", PID_ACK);
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        sends = 0;
        for (int k = 0; k < 9; k++) begin
            wait_tx(10, got);
            check($sformatf("rt%0d_got", k), {63'd0, got}, 64'd1);
            if (got) begin
                sends++;
                check($sformatf("rt%0d_data", k), tx_data, 64'hC0DE_0000_0000_0042);
                do_hs($sformatf("rt%0d_hs", k), PID_DATA0);
            end
            send_pkt(PID_NAK, 7'd0, 4'd0, 64'd0, 1'b1);
        end
        wait_tx(20, got);
        check("rt_nomore", {63'd0, got}, 64'd0);
        check("rt_sends", 64'(sends), 64'd9);
        // Address is kept after exhaustion: a new IN reads again
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        check("rt_keep_re", {63'd0, mem_re}, 64'd1);
        check("rt_keep_addr", {48'd0, mem_addr}, 64'h42);
        wait_tx(10, got);
        check("rt_keep_got", {63'd0, got}, 64'd1);
        if (got) do_hs("rt_keep_hs", PID_DATA0);
        send_pkt(PID_ACK, 7'd0, 4'd0, 64'd0, 1'b1);

        // Data arrives in the last waiting cycle: still accepted
        send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
        repeat (253) @(negedge clk);
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h77, 1'b1);
        check("to_edge_req", {63'd0, tx_req}, 64'd1);
        if (tx_req) do_hs("to_edge_hs", PID_ACK);

        // 255 idle cycles abandon the transaction
        send_pkt(PID_OUT, 7'd5, 4'd4, 64'd0, 1'b1);
        repeat (254) @(negedge clk);
        send_pkt(PID_DATA0, 7'd0, 4'd0, 64'h99, 1'b1);
        check("to_quiet", {62'd0, tx_req, mem_we}, 64'd0);
        @(negedge clk);

        // Reset in the middle of a DATA0 send
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        check("mr_addr", {48'd0, mem_addr}, 64'h77);
        wait_tx(10, got);
        check("mr_got", {63'd0, got}, 64'd1);
        rst_L = 1'b0;
        #1;
        check("mr_req", {63'd0, tx_req}, 64'd0);
        check("mr_pid", {60'd0, tx_pid}, 64'd0);
        check("mr_data", tx_data, 64'd0);
        check("mr_mem", {mem_addr, 46'd0, mem_we, mem_re}, 64'd0);
        check("mr_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        rst_L = 1'b1;
        send_pkt(PID_IN, 7'd5, 4'd8, 64'd0, 1'b1);
        check("post_rst_re", {63'd0, mem_re}, 64'd0);
        do_hs("post_rst", PID_NAK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
